// File: rtl/h14tx_pkg.sv
// Shared HDMI 1.4 TX types: TMDS period encoding, island FSM states and
// the fixed lengths of preambles, guard bands, packets and lookahead windows.
package h14tx_pkg;

  typedef enum logic [2:0] {
    PER_CONTROL,
    PER_VIDEO_PREAMBLE,
    PER_VIDEO_GUARD,
    PER_VIDEO_ACTIVE,
    PER_DI_PREAMBLE,
    PER_DI_GUARD,
    PER_DI_ACTIVE
  } period_t;

  typedef enum logic [2:0] {
    ISL_IDLE,
    ISL_PRE,
    ISL_LGUARD,
    ISL_ACTIVE,
    ISL_TGUARD
  } island_state_t;

  localparam int PRE_LEN    = 8;
  localparam int GUARD_LEN  = 2;
  localparam int PKT_LEN    = 32;
  localparam int ISLAND_WIN = 58;
  localparam int CONT_WIN   = 48;
  localparam int VID_AHEAD  = 11;

  localparam logic [2:0] PRE_LAST   = 3'(PRE_LEN - 1);
  localparam logic [2:0] GUARD_LAST = 3'(GUARD_LEN - 1);
  localparam logic [4:0] PHASE_LAST = 5'(PKT_LEN - 1);

  function automatic period_t island_period(input island_state_t s);
    case (s)
      ISL_PRE:                island_period = PER_DI_PREAMBLE;
      ISL_LGUARD, ISL_TGUARD: island_period = PER_DI_GUARD;
      ISL_ACTIVE:             island_period = PER_DI_ACTIVE;
      default:                island_period = PER_CONTROL;
    endcase
  endfunction

endpackage

// File: rtl/h14tx_lookahead_line.sv
// Timing delay line: slot 0 drives the delayed outputs; the de windows are
// evaluated on the line as it will stand next cycle, so decisions registered
// now line up with the delayed timing.
module h14tx_lookahead_line
  import h14tx_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AHEAD = VID_AHEAD,
  parameter int WIN_A = ISLAND_WIN,
  parameter int WIN_B = CONT_WIN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_de,
  input  logic             i_hsync,
  input  logic             i_vsync,
  output logic             o_de,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic [AHEAD-1:0] o_de_ahead,
  output logic             o_win_a_busy,
  output logic             o_win_b_busy
);

  logic [DEPTH-1:0] r_de, r_hs, r_vs;
  logic [DEPTH-1:0] w_de_nxt, w_hs_nxt, w_vs_nxt;

  assign w_de_nxt = {i_de,    r_de[DEPTH-1:1]};
  assign w_hs_nxt = {i_hsync, r_hs[DEPTH-1:1]};
  assign w_vs_nxt = {i_vsync, r_vs[DEPTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_de <= '0;
      r_hs <= '0;
      r_vs <= '0;
    end else begin
      r_de <= w_de_nxt;
      r_hs <= w_hs_nxt;
      r_vs <= w_vs_nxt;
    end
  end

  assign o_de         = r_de[0];
  assign o_hsync      = r_hs[0];
  assign o_vsync      = r_vs[0];
  assign o_de_ahead   = w_de_nxt[AHEAD-1:0];
  assign o_win_a_busy = |w_de_nxt[WIN_A-1:0];
  assign o_win_b_busy = |w_de_nxt[WIN_B-1:0];

endmodule

// File: rtl/h14tx_period_scheduler.sv
// TMDS period scheduler: video preamble/guard insertion from the lookahead
// line, plus data-island packing into blanking with a packet handshake.
module h14tx_period_scheduler
  import h14tx_pkg::*;
#(
  parameter int Lookahead  = 64,
  parameter int MaxPackets = 18,
  parameter int MinCtl     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  input  logic       pkt_valid,
  output logic       pkt_ready,
  output logic [4:0] pkt_phase,
  output logic       de_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output period_t    period
);

  localparam int CTL_W = (MinCtl < 1) ? 1 : $clog2(MinCtl + 1);
  localparam logic [CTL_W-1:0] CTL_MAX = CTL_W'(MinCtl);
  localparam logic [4:0]       PKT_MAX = 5'(MaxPackets);

  logic [VID_AHEAD-1:0] w_ahead;
  logic                 w_isl_busy, w_cont_busy;
  period_t              w_vid;

  island_state_t        r_state, w_state_nxt;
  logic [2:0]           r_cnt, w_cnt_nxt;
  logic [4:0]           r_phase, w_phase_nxt;
  logic [4:0]           r_npkt, w_npkt_nxt;
  logic [CTL_W-1:0]     r_ctl, w_ctl_nxt;
  period_t              r_period, w_period_nxt;
  logic                 w_ready, w_start, w_cont;

  h14tx_lookahead_line #(
    .DEPTH (Lookahead),
    .AHEAD (VID_AHEAD),
    .WIN_A (ISLAND_WIN),
    .WIN_B (CONT_WIN)
  ) u_line (
    .clk          (clk),
    .rst          (rst),
    .i_de         (de_i),
    .i_hsync      (hsync_i),
    .i_vsync      (vsync_i),
    .o_de         (de_o),
    .o_hsync      (hsync_o),
    .o_vsync      (vsync_o),
    .o_de_ahead   (w_ahead),
    .o_win_a_busy (w_isl_busy),
    .o_win_b_busy (w_cont_busy)
  );

  // First de in the lookahead picks the video period; short blanking
  // naturally eats the preamble before the guard.
  always_comb begin
    w_vid = PER_CONTROL;
    if (w_ahead[0])                        w_vid = PER_VIDEO_ACTIVE;
    else if (|w_ahead[2:1])                w_vid = PER_VIDEO_GUARD;
    else if (|w_ahead[VID_AHEAD-1:3])      w_vid = PER_VIDEO_PREAMBLE;
  end

  assign w_start = (r_state == ISL_IDLE) && (w_vid == PER_CONTROL) &&
                   (r_ctl >= CTL_MAX) && pkt_valid && !w_isl_busy;
  assign w_cont  = (r_phase == PHASE_LAST) && pkt_valid &&
                   (r_npkt < PKT_MAX) && !w_cont_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_npkt_nxt  = r_npkt;
    w_ready     = 1'b0;
    case (r_state)
      ISL_IDLE: begin
        if (w_start) begin
          w_state_nxt = ISL_PRE;
          w_cnt_nxt   = '0;
          w_npkt_nxt  = 5'd1;
          w_ready     = 1'b1;
        end
      end
      ISL_PRE: begin
        if (r_cnt == PRE_LAST) begin
          w_state_nxt = ISL_LGUARD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ISL_LGUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = ISL_ACTIVE;
          w_phase_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      ISL_ACTIVE: begin
        if (r_phase == PHASE_LAST) begin
          w_phase_nxt = '0;
          if (w_cont) begin
            w_npkt_nxt = r_npkt + 5'd1;
            w_ready    = 1'b1;
          end else begin
            w_state_nxt = ISL_TGUARD;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_phase_nxt = r_phase + 5'd1;
        end
      end
      ISL_TGUARD: begin
        if (r_cnt == GUARD_LAST) begin
          w_state_nxt = ISL_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = ISL_IDLE;
        w_cnt_nxt   = '0;
        w_phase_nxt = '0;
      end
    endcase

    w_period_nxt = (w_state_nxt == ISL_IDLE) ? w_vid : island_period(w_state_nxt);
    // ctl_cnt tracks the period being registered, so it lines up with period
    if (w_period_nxt == PER_CONTROL)
      w_ctl_nxt = (r_ctl == CTL_MAX) ? r_ctl : r_ctl + 1'b1;
    else
      w_ctl_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ISL_IDLE;
      r_cnt    <= '0;
      r_phase  <= '0;
      r_npkt   <= '0;
      r_ctl    <= '0;
      r_period <= PER_CONTROL;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_phase  <= w_phase_nxt;
      r_npkt   <= w_npkt_nxt;
      r_ctl    <= w_ctl_nxt;
      r_period <= w_period_nxt;
    end
  end

  assign pkt_ready = w_ready & ~rst;
  assign pkt_phase = r_phase;
  assign period    = r_period;

endmodule

// File: tb/tb_h14tx_period_scheduler.sv
// Randomized line/blanking stimulus against a schedule-level reference model;
// expected records are queued per cycle and checked by an independent monitor.
module tb_h14tx_period_scheduler;
  import h14tx_pkg::*;

  localparam int LOOK   = 64;
  localparam int MAXP   = 2;
  localparam int MINCTL = 4;
  localparam int MAXC   = 16384;

  logic       clk = 1'b0;
  logic       rst, de_i, hsync_i, vsync_i, pkt_valid;
  logic       pkt_ready, de_o, hsync_o, vsync_o;
  logic [4:0] pkt_phase;
  period_t    period;

  always #5 clk = ~clk;

  h14tx_period_scheduler #(
    .Lookahead  (LOOK),
    .MaxPackets (MAXP),
    .MinCtl     (MINCTL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .de_i      (de_i),
    .hsync_i   (hsync_i),
    .vsync_i   (vsync_i),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_phase (pkt_phase),
    .de_o      (de_o),
    .hsync_o   (hsync_o),
    .vsync_o   (vsync_o),
    .period    (period)
  );

  typedef struct {
    logic       de, hs, vs, rdy;
    period_t    per;
    logic [4:0] ph;
    bit         chk_ph;
  } rec_t;

  rec_t q[$];
  rec_t cur, nxt;
  bit   have_cur = 0;
  bit   arm = 0;

  logic in_de [MAXC];
  logic in_hs [MAXC];
  logic in_vs [MAXC];

  int j = 0;
  int last_rst = -1000;
  int last_busy = 0;
  bit isl_on = 0, closing = 0;
  int isl_s = 0, act_end = 0, npk = 0;
  int checks = 0, errors = 0;

  // Output at cycle k is the input of cycle k-LOOK unless a reset wiped it.
  function automatic logic [2:0] dout(input int k);
    int i;
    i = k - LOOK;
    if (i < 0 || i <= last_rst) return 3'b000;
    return {in_de[i], in_hs[i], in_vs[i]};
  endfunction

  function automatic logic dout_de(input int k);
    logic [2:0] v;
    v = dout(k);
    return v[2];
  endfunction

  function automatic bit clear(input int m, input int n);
    for (int k = m; k < m + n; k++)
      if (dout_de(k)) return 0;
    return 1;
  endfunction

  function automatic period_t video(input int m);
    if (dout_de(m)) return PER_VIDEO_ACTIVE;
    for (int r = 1; r <= 10; r++)
      if (dout_de(m + r)) return (r <= 2) ? PER_VIDEO_GUARD : PER_VIDEO_PREAMBLE;
    return PER_CONTROL;
  endfunction

  // Drive one cycle, predict this cycle's pkt_ready and next cycle's outputs.
  task automatic step(input logic de, input logic hs, input logic vs,
                      input logic pv, input logic r_in);
    logic       r, rdy;
    logic [2:0] o;
    int         m;
    if (j >= MAXC - 2) begin
      $display("FAIL cycle_budget: reached %0d cycles, limit %0d", j, MAXC - 2);
      $fatal(1);
    end
    r = r_in;
    if (arm && have_cur && cur.per == PER_DI_ACTIVE && cur.ph == 5'd2) begin
      r   = 1'b1;
      arm = 0;
    end
    de_i = de; hsync_i = hs; vsync_i = vs; pkt_valid = pv; rst = r;
    in_de[j] = de; in_hs[j] = hs; in_vs[j] = vs;
    m   = j + 1;
    rdy = 1'b0;
    if (r) begin
      last_rst   = j;
      isl_on     = 0;
      closing    = 0;
      last_busy  = m;
      nxt.per    = PER_CONTROL;
      nxt.de     = 1'b0;
      nxt.hs     = 1'b0;
      nxt.vs     = 1'b0;
      nxt.ph     = 5'd0;
      nxt.chk_ph = 1;
    end else begin
      if (isl_on && !closing && m == act_end) begin
        if (pv && npk < MAXP && clear(m, 48)) begin
          npk++;
          act_end += 32;
          rdy = 1'b1;
        end else begin
          closing = 1;
        end
      end
      if (isl_on && closing && m >= act_end + 2) isl_on = 0;
      if (!isl_on && pv && (j - last_busy) >= MINCTL && clear(m, 58)) begin
        isl_on  = 1;
        closing = 0;
        isl_s   = m;
        act_end = m + 10 + 32;
        npk     = 1;
        rdy     = 1'b1;
      end
      nxt.ph     = 5'd0;
      nxt.chk_ph = 0;
      if (isl_on) begin
        if (m < isl_s + 8)       nxt.per = PER_DI_PREAMBLE;
        else if (m < isl_s + 10) nxt.per = PER_DI_GUARD;
        else if (m < act_end) begin
          nxt.per    = PER_DI_ACTIVE;
          nxt.ph     = 5'((m - isl_s - 10) % 32);
          nxt.chk_ph = 1;
        end else                 nxt.per = PER_DI_GUARD;
      end else begin
        nxt.per = video(m);
      end
      o = dout(m);
      nxt.de = o[2];
      nxt.hs = o[1];
      nxt.vs = o[0];
      if (nxt.per != PER_CONTROL) last_busy = m;
    end
    if (have_cur) begin
      cur.rdy = rdy;
      q.push_back(cur);
    end
    cur = nxt;
    have_cur = 1;
    @(posedge clk);
    #1;
    j++;
  endtask

  task automatic line_seg(input int blank, input int act, input int pvmode);
    for (int i = 0; i < blank + act; i++) begin
      logic pv;
      pv = (pvmode == 1) || (pvmode == 2 && $urandom_range(0, 3) != 0);
      step(i >= blank, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pv, 1'b0);
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, j, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    rec_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("de_o", 32'(de_o), 32'(e.de));
      chk("hsync_o", 32'(hsync_o), 32'(e.hs));
      chk("vsync_o", 32'(vsync_o), 32'(e.vs));
      chk("period", 32'(period), 32'(e.per));
      chk("pkt_ready", 32'(pkt_ready), 32'(e.rdy));
      if (e.chk_ph) chk("pkt_phase", 32'(pkt_phase), 32'(e.ph));
    end
  end

  int tbl [10] = '{1, 6, 9, 10, 11, 30, 57, 58, 62, 120};

  initial begin
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    line_seg(80, 20, 0);
    line_seg(120, 20, 1);
    line_seg(57, 20, 1);
    line_seg(300, 20, 1);
    line_seg(6, 20, 1);
    line_seg(6, 20, 1);
    arm = 1;
    line_seg(120, 20, 1);
    line_seg(90, 20, 1);
    for (int s = 0; s < 40; s++) begin
      int b, a, pm;
      b  = ($urandom_range(0, 1) != 0) ? tbl[$urandom_range(0, 9)] : int'($urandom_range(1, 200));
      a  = int'($urandom_range(1, 40));
      pm = int'($urandom_range(1, 2));
      line_seg(b, a, pm);
    end
    line_seg(100, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (arm) begin
      errors++;
      $display("FAIL reset_trigger: island active cycle never reached, armed=%0d expected 0", arm);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
